// File: rtl/pedo_pkg.sv
// rtl/pedo_pkg.sv - opcodes, spare address, FSM states and instruction encoders
package pedo_pkg;

  localparam logic [3:0] OP_COUNT  = 4'b1100;
  localparam logic [3:0] OP_CLEAR  = 4'b0010;
  localparam logic [3:0] OP_DUAL   = 4'b1010;
  localparam logic [3:0] OP_SINGLE = 4'b0110;
  localparam logic [2:0] SPARE_ADDR = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } sched_state_e;

  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] data;
  } wr_entry_t;

  function automatic logic [31:0] enc_count(input logic [7:0] a, input logic [7:0] b);
    return {12'd0, b, a, OP_COUNT};
  endfunction

  function automatic logic [31:0] enc_clear();
    return {28'd0, OP_CLEAR};
  endfunction

  function automatic logic [31:0] enc_dual(input wr_entry_t e1, input wr_entry_t e2);
    return {6'd0, e2.data, e2.addr, e1.data, e1.addr, OP_DUAL};
  endfunction

  // A single update names the spare register as its second slot so the core ignores it.
  function automatic logic [31:0] enc_single(input wr_entry_t e1);
    return {6'd0, 8'd0, SPARE_ADDR, e1.data, e1.addr, OP_SINGLE};
  endfunction

endpackage

// File: rtl/pedo_instr_sched_if.sv
// rtl/pedo_instr_sched_if.sv - sample, weight-write and instruction handshakes of the scheduler
interface pedo_instr_sched_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          sample_valid;
  logic          sample_ready;
  logic [7:0]    sample_a;
  logic [7:0]    sample_b;
  logic          wr_valid;
  logic          wr_ready;
  logic [2:0]    wr_addr;
  logic [7:0]    wr_data;
  logic          clear_req;
  logic          flush;
  logic          instr_valid;
  logic          instr_ready;
  logic [31:0]   instruction;
  logic          wr_drop;
  logic [CW-1:0] fifo_count;

  modport master (
    output sample_valid, sample_a, sample_b, wr_valid, wr_addr, wr_data,
           clear_req, flush, instr_ready,
    input  sample_ready, wr_ready, instr_valid, instruction, wr_drop, fifo_count
  );

  modport slave (
    input  sample_valid, sample_a, sample_b, wr_valid, wr_addr, wr_data,
           clear_req, flush, instr_ready,
    output sample_ready, wr_ready, instr_valid, instruction, wr_drop, fifo_count
  );

endinterface

// File: rtl/pedo_wr_fifo.sv
// rtl/pedo_wr_fifo.sv - in-order weight-write queue exposing the two head entries
module pedo_wr_fifo
  import pedo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  wr_entry_t              push_entry,
  input  logic                   pop1,
  input  logic                   pop2,
  input  logic                   clr,
  output wr_entry_t              head0,
  output wr_entry_t              head1,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wr_entry_t     mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr_p1;
  logic [1:0]    pop_amt;

  assign rd_ptr_p1 = rd_ptr + AW'(1);
  assign head0     = mem[rd_ptr];
  assign head1     = mem[rd_ptr_p1];
  assign full      = (count == CW'(DEPTH));
  assign pop_amt   = pop2 ? 2'd2 : (pop1 ? 2'd1 : 2'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      // A clear discards everything already queued but keeps a same-cycle push.
      if (clr) begin
        rd_ptr <= wr_ptr;
        count  <= push ? CW'(1) : '0;
      end else begin
        rd_ptr <= rd_ptr + AW'(pop_amt);
        count  <= count + CW'(push) - CW'(pop_amt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/pedo_instr_sched.sv
// rtl/pedo_instr_sched.sv - arbitrates clear, weight writes and step samples into core instructions
module pedo_instr_sched
  import pedo_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int WAIT_MAX   = 8,
  parameter int STARVE_MAX = 4
) (
  input logic               clk,
  input logic               reset_n,
  pedo_instr_sched_if.slave bus
);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int AGE_W = $clog2(WAIT_MAX + 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  sched_state_e     state_q, state_d;
  logic [31:0]      instr_q, instr_d;
  logic             clear_pend;
  logic             wr_drop_q;
  logic [AGE_W-1:0] age_cnt;
  logic [STV_W-1:0] starve_cnt;

  wr_entry_t        head0, head1, push_entry;
  logic [CW-1:0]    fifo_cnt;
  logic             fifo_full;

  logic load_en, wr_accept, push, fifo_empty;
  logic two_plus, dual_ok, lone_ok, wt_elig;
  logic clr_win, wt_win, cnt_win, any_win;
  logic pop1, pop2, fifo_clr;

  assign bus.instr_valid  = (state_q == HOLD);
  assign bus.instruction  = instr_q;
  assign bus.wr_ready     = !fifo_full;
  assign bus.wr_drop      = wr_drop_q;
  assign bus.fifo_count   = fifo_cnt;

  assign load_en    = !bus.instr_valid || bus.instr_ready;
  assign wr_accept  = bus.wr_valid && !fifo_full;
  assign push       = wr_accept && (bus.wr_addr != SPARE_ADDR);
  assign push_entry = '{addr: bus.wr_addr, data: bus.wr_data};
  assign fifo_empty = (fifo_cnt == '0);

  // Equal head addresses must not share a dual update, or the write order would be lost.
  assign two_plus = (fifo_cnt >= CW'(2));
  assign dual_ok  = two_plus && (head0.addr != head1.addr);
  assign lone_ok  = (fifo_cnt == CW'(1)) && ((age_cnt >= AGE_W'(WAIT_MAX - 1)) || bus.flush);
  assign wt_elig  = two_plus || lone_ok;

  assign clr_win = clear_pend;
  assign wt_win  = !clear_pend && wt_elig
                   && ((starve_cnt == STV_W'(STARVE_MAX)) || !bus.sample_valid);
  assign cnt_win = !clear_pend && !wt_win && bus.sample_valid;
  assign any_win = clr_win || wt_win || cnt_win;

  assign pop2     = load_en && wt_win && dual_ok;
  assign pop1     = load_en && wt_win && !dual_ok;
  assign fifo_clr = load_en && clr_win;

  assign bus.sample_ready = load_en && cnt_win;

  pedo_wr_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_entry(push_entry),
    .pop1      (pop1),
    .pop2      (pop2),
    .clr       (fifo_clr),
    .head0     (head0),
    .head1     (head1),
    .count     (fifo_cnt),
    .full      (fifo_full)
  );

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    if (load_en) begin
      state_d = any_win ? HOLD : IDLE;
      if (clr_win)      instr_d = enc_clear();
      else if (wt_win)  instr_d = dual_ok ? enc_dual(head0, head1) : enc_single(head0);
      else if (cnt_win) instr_d = enc_count(bus.sample_a, bus.sample_b);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clear_pend <= 1'b0;
      wr_drop_q  <= 1'b0;
      age_cnt    <= '0;
      starve_cnt <= '0;
    end else begin
      if (fifo_clr)           clear_pend <= 1'b0;
      else if (bus.clear_req) clear_pend <= 1'b1;

      wr_drop_q <= wr_accept && (bus.wr_addr == SPARE_ADDR);

      if (push || pop1 || pop2 || fifo_clr || (fifo_cnt != CW'(1)))
        age_cnt <= '0;
      else if (age_cnt != AGE_W'(WAIT_MAX))
        age_cnt <= age_cnt + AGE_W'(1);

      // Bounds how long sample traffic can hold back a pending write.
      if ((load_en && wt_win) || fifo_empty || fifo_clr)
        starve_cnt <= '0;
      else if (load_en && cnt_win && (starve_cnt != STV_W'(STARVE_MAX)))
        starve_cnt <= starve_cnt + STV_W'(1);
    end
  end

endmodule
